register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file.
- Adds a configurable number of read ports, a second write port with fixed collision priority, optional write-to-read bypass, and an optional hardwired-zero register.
- Adds a hardware clear sequencer with a busy/done handshake.
- Sits between the decode stage (read addresses) and the writeback stage (write ports) of the microprocessor datapath.

Parameters:
DATA_WIDTH, 16, width of each register.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH registers.
NUM_READ, 2, number of read ports (1..8).
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return stored value only.
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
we0  input  1  write enable, port 0.
waddr0  input  ADDR_WIDTH  write address, port 0.
wdata0  input  DATA_WIDTH  write data, port 0.
we1  input  1  write enable, port 1 (priority port).
waddr1  input  ADDR_WIDTH  write address, port 1.
wdata1  input  DATA_WIDTH  write data, port 1.
raddr  input  NUM_READ*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
rdata  output  NUM_READ*DATA_WIDTH  read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
clear_start  input  1  request to zero all registers.
clear_busy  output  1  clear sequence in progress.
clear_done  output  1  one-cycle pulse when clear completes.

Behaviour:
Reset:
- All registers, clear index and FSM go to 0/IDLE immediately.
- clear_busy=0, clear_done=0.
- rdata reflects zeroed storage combinationally.

Writes:
- Occur at the rising edge when weN=1 and clear_busy=0.
- If we0 and we1 are both set with waddr0==waddr1, only wdata1 is stored.
- Writes to different addresses both take effect on the same edge.
- ZERO_REG=1: writes to address 0 are discarded.

Reads:
- Combinational, zero latency, independent per port.
- Any number of ports may read the same address.
- BYPASS=1 and clear_busy=0: if a read address matches an enabled write address, rdata returns the write data in the same cycle, with port 1 taking priority over port 0. Otherwise the stored value is returned.
- ZERO_REG=1: address 0 reads 0, overriding bypass.

Clear FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on an edge with clear_start=1. The clear index is set to 0.
- User writes sampled on that same edge still commit.
- In CLEAR, each edge zeroes reg[index] and increments index.
- When index==DEPTH-1 the FSM returns to IDLE and clear_done is registered high for the next cycle only.
- clear_busy is high for exactly DEPTH cycles.
- While busy: user writes are ignored, clear_start is ignored, and bypass is disabled. Reads return current storage, which may be partially cleared.
- clear_start held high through completion re-triggers a new sequence on the edge where the FSM is back in IDLE, i.e. the cycle clear_done is high.
- Reset mid-clear aborts: everything returns to zero and IDLE, and clear_done is not pulsed.

Test Plan:
- Reset, then write 0xA5A5 to r3 via port 0 and 0x1234 to r7 via port 1 in the same cycle; next cycle raddr={r7,r3} -> rdata={0x1234,0xA5A5}.
- Both ports write r5 in the same cycle (port0=0x1111, port1=0x2222) -> r5 reads 0x2222 afterwards; with BYPASS=1, a same-cycle read of r5 returns 0x2222.
- BYPASS=1: write 0xBEEF to r9 while reading r9 -> 0xBEEF in the same cycle. BYPASS=0: the same stimulus returns the old value 0x0000, and 0xBEEF appears the next cycle.
- Fill r0..r15 with values 0x0100+i, pulse clear_start -> clear_busy high for 16 cycles, clear_done high for 1 cycle afterwards, all registers read 0. A we0 to r2 with 0xFFFF issued mid-sequence leaves r2=0.
- ZERO_REG=1: write 0x7777 to r0 -> r0 reads 0x0000, including in the same cycle with bypass.
- Assert reset at clear cycle 5 of 16 -> clear_busy=0 immediately, no clear_done pulse, all registers 0. A subsequent clear_start runs a full 16-cycle sequence.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational read ports, two write ports (port 1 wins on collision), hardware clear sequencer.
// Latency: reads are zero-latency (same-cycle bypass optional); writes commit on the rising edge; clear takes DEPTH cycles.
// Backpressure: none; user writes and clear_start are dropped while clear_busy is high.
module register_file_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             we0,
    input  logic [ADDR_WIDTH-1:0]            waddr0,
    input  logic [DATA_WIDTH-1:0]            wdata0,
    input  logic                             we1,
    input  logic [ADDR_WIDTH-1:0]            waddr1,
    input  logic [DATA_WIDTH-1:0]            wdata1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata,
    input  logic                             clear_start,
    output logic                             clear_busy,
    output logic                             clear_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_idx;
    logic [ADDR_WIDTH-1:0]   clr_idx_nxt;
    logic                    done_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Register 0 is only special when the hardwired-zero option is enabled.
    logic wr0_ok;
    logic wr1_ok;
    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    assign clear_busy = (state == CLEAR);

    // Clear sequencer next-state: walk every index once, then pulse done.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any clear without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_idx    <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_idx    <= clr_idx_nxt;
            clear_done <= done_nxt;
        end
    end

    // Storage update: clear owns the array while busy, otherwise port 1 lands last so it wins a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_busy) begin
            mem[clr_idx] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;

        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux: stored value, optionally overridden by an in-flight write, then the hardwired zero.
        always_comb begin
            rv = mem[ra];
            if ((BYPASS != 0) && !clear_busy) begin
                if (we0 && (waddr0 == ra)) begin
                    rv = wdata0;
                end
                if (we1 && (waddr1 == ra)) begin
                    rv = wdata1;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
            end
        end

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rv;
    end

endmodule
